dram_bus_arbiter: RTL and testbench
===================================

// Module: dram_bus_arbiter
// PURPOSE
//  Two-master arbiter placed between the CPU data port (M0) and a second bus
//  master (M1: program loader / DMA) on one side and the Bridge on the other.
//  Grants the single Bridge port to one master at a time: round-robin on ties,
//  burst-length fairness limit, single-cycle transfers matching the async-read /
//  sync-write DRAM and peripheral paths behind the Bridge.
// PARAMETERS
//  AW         32  address width, both masters and slave
//  DW         32  data width, both masters and slave
//  MAX_BURST  8   max consecutive transfers by one owner while the other requests (>=1)
//  RESET_PRI  0   master treated as "not last owner" after reset (wins first tie)
// PORTS
//  cpu_clk    in   1   clock (CPU clock domain)
//  cpu_rst    in   1   synchronous reset, active-high
//  m0_req     in   1   M0 requests bus; held high for the whole burst
//  m0_addr    in   AW  M0 address
//  m0_wen     in   1   M0 write enable
//  m0_wdata   in   DW  M0 write data
//  m0_gnt     out  1   M0 owns bus (registered)
//  m0_ack     out  1   M0 transfer completes this cycle
//  m0_rdata   out  DW  read data to M0
//  m1_*       --   --  identical set for M1
//  s_addr     out  AW  to Bridge addr_from_cpu
//  s_wen      out  1   to Bridge wen_from_cpu
//  s_wdata    out  DW  to Bridge wdata_from_cpu
//  s_rdata    in   DW  from Bridge rdata_to_cpu
// BEHAVIOUR
//  - States IDLE, OWN0, OWN1; state drives gnt (m0_gnt = OWN0, m1_gnt = OWN1).
//  - Reset: IDLE, gnts 0, acks 0, burst_cnt 0, last_owner = !RESET_PRI.
//  - IDLE: one req -> that OWN next edge; both -> master != last_owner; none -> stay.
//    Grant latency: 1 cycle from req to gnt; no transfer occurs in IDLE.
//  - OWNn, reqn=1: one transfer/cycle. s_addr/s_wdata = mn_*, s_wen = mn_wen,
//    mn_ack = 1, mn_rdata = s_rdata (combinational). burst_cnt++ (saturating).
//  - OWNn, reqn=0: no transfer, ack 0, s_wen 0; next = OWN(other) if other req,
//    else IDLE; burst_cnt <= 0; last_owner <= n.
//  - Fairness: transfer with burst_cnt == MAX_BURST-1 and other req=1 -> that
//    transfer completes, next = OWN(other), burst_cnt <= 0, last_owner <= n.
//    If other not requesting, owner keeps bus; burst_cnt saturates at MAX_BURST-1.
//  - Non-owner: ack 0, rdata 0. IDLE: s_addr 0, s_wdata 0, s_wen 0.
//  - s_wen never 1 unless a gnt is 1 and that master's req is 1 (no spurious writes).
//  - Reset mid-burst: next edge IDLE; pending write in that cycle is suppressed
//    (s_wen forced 0 while cpu_rst=1).
//  - Master dropping req mid-burst is legal; it re-arbitrates from IDLE rules.
// CONFIGURATION
//  ARB_LOCK_EN defined: extra inputs m0_lock, m1_lock (1 bit). While owner's
//   lock=1 and req=1 the fairness switch is suppressed; burst_cnt still saturates.
//   Lock of the non-owner is ignored.
//  ARB_LOCK_EN undefined: no lock ports; fairness rule always applies.
// TESTING
//  1 M0 req, wen=1, addr 0x0000_0010, wdata 0xDEAD_BEEF -> gnt0 at cycle+1,
//    same cycle s_wen=1, s_addr/s_wdata match, m0_ack=1; M1 outputs 0.
//  2 Both req on first cycle after reset, RESET_PRI=0 -> M0 granted first; after
//    M0 drops req, M1 granted next edge with no IDLE gap.
//  3 MAX_BURST=4, both held high -> grant pattern 4xM0, 4xM1, 4xM0; acks
//    exactly one per cycle, never both.
//  4 M1 read addr 0x8000_0000 (Bridge returns 0x0000_00A5) -> m1_rdata=0x0000_00A5
//    in ack cycle; m0_rdata=0.
//  5 cpu_rst asserted during M1 write burst -> s_wen=0 that cycle, next edge IDLE,
//    gnts 0, burst_cnt 0; after release, tie resolves per RESET_PRI.
//  6 ARB_LOCK_EN, MAX_BURST=2, m0_lock=1, both req -> M0 keeps bus until lock or
//    req drops; then M1 granted next edge.

Source files
------------

// File: rtl/dram_bus_arbiter_if.sv
// dram_bus_arbiter_if: two-master / one-slave bus bundle around the Bridge arbiter.
// ARB_LOCK_EN adds per-master lock inputs.
interface dram_bus_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
   logic          m0_req, m0_wen, m0_gnt, m0_ack;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_wen, m1_gnt, m1_ack;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [AW-1:0] s_addr;
   logic          s_wen;
   logic [DW-1:0] s_wdata, s_rdata;
`ifdef ARB_LOCK_EN
   logic          m0_lock, m1_lock;
   modport slave (input m0_req, m0_addr, m0_wen, m0_wdata, m0_lock,
                  input m1_req, m1_addr, m1_wen, m1_wdata, m1_lock, s_rdata,
                  output m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
                  output s_addr, s_wen, s_wdata);
   modport master (output m0_req, m0_addr, m0_wen, m0_wdata, m0_lock,
                   output m1_req, m1_addr, m1_wen, m1_wdata, m1_lock, s_rdata,
                   input m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
                   input s_addr, s_wen, s_wdata);
`else
   modport slave (input m0_req, m0_addr, m0_wen, m0_wdata,
                  input m1_req, m1_addr, m1_wen, m1_wdata, s_rdata,
                  output m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
                  output s_addr, s_wen, s_wdata);
   modport master (output m0_req, m0_addr, m0_wen, m0_wdata,
                   output m1_req, m1_addr, m1_wen, m1_wdata, s_rdata,
                   input m0_gnt, m0_ack, m0_rdata, m1_gnt, m1_ack, m1_rdata,
                   input s_addr, s_wen, s_wdata);
`endif
endinterface

// File: rtl/dram_bus_arbiter.sv
// dram_bus_arbiter: round-robin two-master arbiter with burst fairness limit for the Bridge port.
// ARB_LOCK_EN: owner's lock suppresses the fairness hand-over.
module dram_bus_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8,
   parameter int RESET_PRI = 0
) (
   input logic                cpu_clk,
   input logic                cpu_rst,
   dram_bus_arbiter_if.slave  bus
);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t        state, state_nxt;
   logic [CW-1:0] burst_cnt, cnt_nxt;
   logic          last_owner, last_nxt;
   logic          own, req_own, req_oth, lock_own, xfer, last_beat;
`ifdef ARB_LOCK_EN
   assign lock_own = own ? bus.m1_lock : bus.m0_lock;
`else
   assign lock_own = 1'b0;
`endif
   assign own       = state == OWN1;
   assign req_own   = own ? bus.m1_req : bus.m0_req;
   assign req_oth   = own ? bus.m0_req : bus.m1_req;
   assign xfer      = state != IDLE && req_own;
   assign last_beat = burst_cnt == CW'(MAX_BURST - 1);
   always_comb begin
      state_nxt = state;
      cnt_nxt   = burst_cnt;
      last_nxt  = last_owner;
      if (state == IDLE)
         state_nxt = (bus.m0_req && (!bus.m1_req || last_owner)) ? OWN0 : bus.m1_req ? OWN1 : IDLE;
      else if (!req_own || (last_beat && req_oth && !lock_own)) begin
         state_nxt = req_oth ? (own ? OWN0 : OWN1) : IDLE;
         cnt_nxt   = '0;
         last_nxt  = own;
      end else
         cnt_nxt = last_beat ? burst_cnt : burst_cnt + 1'b1;
   end
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= RESET_PRI == 0;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= cnt_nxt;
         last_owner <= last_nxt;
      end
   end
   assign bus.m0_gnt   = state == OWN0;
   assign bus.m1_gnt   = state == OWN1;
   assign bus.m0_ack   = xfer && !own;
   assign bus.m1_ack   = xfer && own;
   assign bus.m0_rdata = bus.m0_ack ? bus.s_rdata : '0;
   assign bus.m1_rdata = bus.m1_ack ? bus.s_rdata : '0;
   assign bus.s_addr   = !xfer ? '0 : own ? bus.m1_addr : bus.m0_addr;
   assign bus.s_wdata  = !xfer ? '0 : own ? bus.m1_wdata : bus.m0_wdata;
   // reset suppresses a write that would otherwise land this cycle
   assign bus.s_wen    = xfer && !cpu_rst && (own ? bus.m1_wen : bus.m0_wen);
endmodule

// File: tb/tb_dram_bus_arbiter.sv
// tb_dram_bus_arbiter: directed scenarios plus random traffic against a transaction-level owner model.
module tb_dram_bus_arbiter;
   localparam int AW = 32, DW = 32, MB = 4;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic          req [2] = '{1'b0, 1'b0};
   logic          wen [2] = '{1'b0, 1'b0};
   logic          lock[2] = '{1'b0, 1'b0};
   logic [AW-1:0] addr[2] = '{32'h0, 32'h0};
   logic [DW-1:0] wdat[2] = '{32'h0, 32'h0};
   logic [DW-1:0] srd = '0;
   dram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   assign bus.m0_req = req[0];
   assign bus.m1_req = req[1];
   assign bus.m0_wen = wen[0];
   assign bus.m1_wen = wen[1];
   assign bus.m0_addr = addr[0];
   assign bus.m1_addr = addr[1];
   assign bus.m0_wdata = wdat[0];
   assign bus.m1_wdata = wdat[1];
   assign bus.s_rdata = srd;
`ifdef ARB_LOCK_EN
   assign bus.m0_lock = lock[0];
   assign bus.m1_lock = lock[1];
`endif
   dram_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .RESET_PRI(0)) dut (
      .cpu_clk(clk), .cpu_rst(rst), .bus(bus));
   int checks = 0, errors = 0;
   // owner: -1 none; run: transfers already done in the current tenure; last: previous owner
   int owner = -1, run = 0, last = 1;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask
   task automatic step();
      int  o;
      bit  x, lk;
      @(negedge clk);
      o = owner < 0 ? 0 : owner;
      x = owner >= 0 && req[o];
`ifdef ARB_LOCK_EN
      lk = lock[o];
`else
      lk = 1'b0;
`endif
      check("gnt0", 64'(bus.m0_gnt), 64'(owner == 0));
      check("gnt1", 64'(bus.m1_gnt), 64'(owner == 1));
      check("ack0", 64'(bus.m0_ack), 64'(x && o == 0));
      check("ack1", 64'(bus.m1_ack), 64'(x && o == 1));
      check("s_wen", 64'(bus.s_wen), 64'(x && wen[o] && !rst));
      check("s_addr", 64'(bus.s_addr), x ? 64'(addr[o]) : 64'd0);
      check("s_wdata", 64'(bus.s_wdata), x ? 64'(wdat[o]) : 64'd0);
      check("rdata0", 64'(bus.m0_rdata), (x && o == 0) ? 64'(srd) : 64'd0);
      check("rdata1", 64'(bus.m1_rdata), (x && o == 1) ? 64'(srd) : 64'd0);
      @(posedge clk);
      if (rst) begin
         owner = -1; run = 0; last = 1;
      end else if (owner < 0) begin
         if (req[0] && req[1]) owner = 1 - last;
         else if (req[0]) owner = 0;
         else if (req[1]) owner = 1;
      end else if (!req[o] || (run >= MB - 1 && req[1 - o] && !lk)) begin
         last = o; owner = req[1 - o] ? 1 - o : -1; run = 0;
      end else run++;
      #1;
   endtask
   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      steps(2);
      rst = 1'b0;
      req[0] = 1; wen[0] = 1; addr[0] = 32'h0000_0010; wdat[0] = 32'hDEAD_BEEF;
      steps(3);
      req[0] = 0; wen[0] = 0;
      steps(2);
      rst = 1; steps(1); rst = 0;
      req[0] = 1; req[1] = 1; addr[0] = 32'h100; addr[1] = 32'h200;
      steps(3);
      req[0] = 0; steps(3);
      req[1] = 0; steps(2);
      req[0] = 1; req[1] = 1; steps(14);
      req[0] = 0; req[1] = 0; steps(2);
      req[1] = 1; addr[1] = 32'h8000_0000; srd = 32'h0000_00A5; steps(3);
      req[1] = 0; steps(1);
      req[1] = 1; wen[1] = 1; wdat[1] = 32'h1234_5678; steps(3);
      rst = 1; steps(1); rst = 0;
      req[0] = 1; steps(3);
      lock[0] = 1; steps(8); lock[0] = 0; steps(4);
      req[0] = 0; req[1] = 0; wen[1] = 0; steps(2);
      for (int i = 0; i < 3000; i++) begin
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 3) == 0) req[m] = ~req[m];
            if ($urandom_range(0, 7) == 0) lock[m] = ~lock[m];
            wen[m]  = $urandom_range(0, 1) == 1;
            addr[m] = $urandom;
            wdat[m] = $urandom;
         end
         srd = $urandom;
         rst = $urandom_range(0, 63) == 0;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
